// File: rtl/dma_c2h_crdt_tx_if.sv
// Credit-gated C2H stream bundle.
// slave: block view; master: source/sink view.
interface dma_c2h_crdt_tx_if;
  logic [511:0] s_tdata;
  logic         s_tlast;
  logic [63:0]  s_tkeep;
  logic [127:0] s_tusr;
  logic [1:0]   s_tch;
  logic         s_tvalid;
  logic         s_tready;

  logic [511:0] m_tdata;
  logic [63:0]  m_tparity;
  logic         m_tlast;
  logic [63:0]  m_tkeep;
  logic [127:0] m_tusr;
  logic         m_tvalid;
  logic [1:0]   m_tch;

  logic         m_crdt;
  logic [1:0]   m_crdt_ch;

  logic [3:0]   crdt_avail;
  logic         crdt_ovf;

  modport slave (
    input  s_tdata, s_tlast, s_tkeep, s_tusr,
    input  s_tch, s_tvalid,
    output s_tready,
    output m_tdata, m_tparity, m_tlast, m_tkeep,
    output m_tusr, m_tvalid, m_tch,
    input  m_crdt, m_crdt_ch,
    output crdt_avail, crdt_ovf
  );

  modport master (
    output s_tdata, s_tlast, s_tkeep, s_tusr,
    output s_tch, s_tvalid,
    input  s_tready,
    input  m_tdata, m_tparity, m_tlast, m_tkeep,
    input  m_tusr, m_tvalid, m_tch,
    output m_crdt, m_crdt_ch,
    input  crdt_avail, crdt_ovf
  );
endinterface

// File: rtl/dma_c2h_crdt_tx.sv
// Per-channel credit gate for C2H beats, one-cycle registered output.
// Optional byte parity on m_tparity: define DMA_C2H_CRDT_PARITY_EN.
module dma_c2h_crdt_tx #(
  parameter int NUM_CH = 4,
  parameter int CRDT_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  dma_c2h_crdt_tx_if.slave bus
);

  logic [NUM_CH-1:0][CRDT_W-1:0] cnt;
  logic [NUM_CH-1:0][CRDT_W-1:0] cnt_nxt;
  logic                          sat_hit;
  logic                          accept;
  logic                          ovf;

  // Ready only looks at the selected counter; reset forces it low.
  assign bus.s_tready = rst_n && (cnt[bus.s_tch] != '0);
  assign accept       = bus.s_tvalid && bus.s_tready;
  assign bus.crdt_ovf = ovf;

  // Availability is taken from registered counters only.
  always_comb begin
    bus.crdt_avail = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      bus.crdt_avail[i] = |cnt[i];
    end
  end

  // Next counter values: consume/return cancel, return saturates.
  always_comb begin
    cnt_nxt = cnt;
    sat_hit = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      logic dec;
      logic inc;
      dec = accept && (bus.s_tch == 2'(i));
      inc = bus.m_crdt && (bus.m_crdt_ch == 2'(i));
      if (inc && !dec) begin
        if (cnt[i] == '1) begin
          sat_hit = 1'b1;
        end else begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end
      end else if (dec && !inc) begin
        cnt_nxt[i] = cnt[i] - 1'b1;
      end
    end
  end

  // Counter state and sticky overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      ovf <= ovf | sat_hit;
    end
  end

  // Output valid and the reset-cleared sideband fields.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.m_tvalid <= 1'b0;
      bus.m_tlast  <= 1'b0;
      bus.m_tch    <= '0;
    end else begin
      bus.m_tvalid <= accept;
      if (accept) begin
        bus.m_tlast <= bus.s_tlast;
        bus.m_tch   <= bus.s_tch;
      end
    end
  end

  // Wide payload fields need no reset; they load on accept only.
  always_ff @(posedge clk) begin
    if (accept) begin
      bus.m_tdata <= bus.s_tdata;
      bus.m_tkeep <= bus.s_tkeep;
      bus.m_tusr  <= bus.s_tusr;
    end
  end

`ifdef DMA_C2H_CRDT_PARITY_EN
  logic [63:0] par_d;
  logic [63:0] par_q;

  // Even parity per byte of the incoming beat.
  always_comb begin
    par_d = '0;
    for (int b = 0; b < 64; b++) begin
      par_d[b] = ^bus.s_tdata[8*b +: 8];
    end
  end

  // Parity registered alongside m_tdata.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_q <= '0;
    end else if (accept) begin
      par_q <= par_d;
    end
  end

  assign bus.m_tparity = par_q;
`else
  assign bus.m_tparity = '0;
`endif

endmodule
